// File: rtl/xgemac_tx_mux.sv
// xgemac_tx_mux
// -------------
// Multi-channel packet transmit multiplexer feeding the XGE MAC pkt_tx
// interface (156.25 MHz domain). Each upstream channel writes 64-bit packet
// words into its own FIFO. A packet-boundary arbiter forwards whole packets,
// never interleaved, onto one pkt_tx stream and honours pkt_tx_full_i.
//
// Build option:
//   XGEMAC_TX_MUX_STRICT_PRIO_EN  defined   -> fixed priority, channel 0 highest
//                                 undefined -> round-robin starting after cur_ch
//
// FIFO entry layout: {sop, eop, mod[2:0], data[63:0]}.
// A word whose head has sop=0 while the block is idle is an orphan and is
// discarded one word per cycle (lowest channel first, only when no grant).

module xgemac_tx_mux #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 64
) (
  input  logic                       clk_156m25,
  input  logic                       reset_156m25_n,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data_i,
  input  logic [NUM_CH-1:0]          ch_val_i,
  input  logic [NUM_CH-1:0]          ch_sop_i,
  input  logic [NUM_CH-1:0]          ch_eop_i,
  input  logic [NUM_CH*3-1:0]        ch_mod_i,
  output logic [NUM_CH-1:0]          ch_full_o,
  output logic [NUM_CH-1:0]          ch_ovf_o,
  output logic [DATA_W-1:0]          pkt_tx_data_o,
  output logic                       pkt_tx_val_o,
  output logic                       pkt_tx_sop_o,
  output logic                       pkt_tx_eop_o,
  output logic [2:0]                 pkt_tx_mod_o,
  input  logic                       pkt_tx_full_i,
  output logic [$clog2(NUM_CH)-1:0]  cur_ch_o
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [CH_W-1:0]  CH_RST_VAL = CH_W'(NUM_CH - 1);

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [2:0]        mod;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Per-channel FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  entry_t            fifo_mem  [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q  [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr_d  [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_q  [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_d  [NUM_CH];
  logic [CNT_W-1:0]  count_q   [NUM_CH];
  logic [CNT_W-1:0]  count_d   [NUM_CH];
  logic [NUM_CH-1:0] ovf_q;
  logic [NUM_CH-1:0] ovf_d;

  entry_t            wr_entry  [NUM_CH];
  entry_t            head      [NUM_CH];
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] not_empty;
  logic [NUM_CH-1:0] grant_elig;
  logic [NUM_CH-1:0] orphan;
  logic [NUM_CH-1:0] pop;

  // ---------------------------------------------------------------------------
  // Arbitration / FSM
  // ---------------------------------------------------------------------------
  state_e            state_q;
  state_e            state_d;
  logic [CH_W-1:0]   cur_ch_q;
  logic [CH_W-1:0]   cur_ch_d;
  logic              grant_valid;
  logic [CH_W-1:0]   grant_ch;
  logic              orphan_valid;
  logic [CH_W-1:0]   orphan_ch;
  logic              fwd_pop;
  entry_t            fwd_entry;

  // ---------------------------------------------------------------------------
  // MAC-side output registers
  // ---------------------------------------------------------------------------
  logic              tx_val_q;
  logic              tx_val_d;
  logic              tx_sop_q;
  logic              tx_sop_d;
  logic              tx_eop_q;
  logic              tx_eop_d;
  logic [2:0]        tx_mod_q;
  logic [2:0]        tx_mod_d;
  logic [DATA_W-1:0] tx_data_q;
  logic [DATA_W-1:0] tx_data_d;

  // Per-channel status: write acceptance, head word, emptiness, eligibility.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wr_entry[c]   = '{sop:  ch_sop_i[c],
                        eop:  ch_eop_i[c],
                        mod:  ch_mod_i[c*3 +: 3],
                        data: ch_data_i[c*DATA_W +: DATA_W]};
      head[c]       = fifo_mem[c][rd_ptr_q[c]];
      not_empty[c]  = (count_q[c] != '0);
      // A full FIFO drops the write even if it is popped this same cycle.
      wr_en[c]      = ch_val_i[c] && (count_q[c] != CNT_FULL);
      grant_elig[c] = not_empty[c] && head[c].sop && !pkt_tx_full_i;
      orphan[c]     = not_empty[c] && !head[c].sop;
      ch_full_o[c]  = (count_q[c] == CNT_FULL);
    end
  end

  // Packet-start arbiter: pick the first eligible channel in search order.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path leaves it unassigned (no latch).
    grant_valid = 1'b0;
    grant_ch    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      int cand;
`ifdef XGEMAC_TX_MUX_STRICT_PRIO_EN
      cand = i;
`else
      cand = (int'(cur_ch_q) + 1 + i) % NUM_CH;
`endif
      if (!grant_valid && grant_elig[cand]) begin
        grant_valid = 1'b1;
        grant_ch    = CH_W'(cand);
      end
    end
  end

  // Orphan finder: lowest-indexed channel whose head word lacks sop.
  always_comb begin
    orphan_valid = 1'b0;
    orphan_ch    = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (orphan[c]) begin
        orphan_valid = 1'b1;
        orphan_ch    = CH_W'(c);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a forwarded eop word always ends the packet.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fwd_pop && !fwd_entry.eop) state_d = ST_XFER;
      ST_XFER: if (fwd_pop &&  fwd_entry.eop) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: which FIFO pops, whether the popped word goes to the MAC.
  always_comb begin
    pop      = '0;
    fwd_pop  = 1'b0;
    cur_ch_d = cur_ch_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          pop[grant_ch] = 1'b1;
          fwd_pop       = 1'b1;
          cur_ch_d      = grant_ch;
        end else if (orphan_valid) begin
          pop[orphan_ch] = 1'b1;
        end
      end
      ST_XFER: begin
        if (not_empty[cur_ch_q] && !pkt_tx_full_i) begin
          pop[cur_ch_q] = 1'b1;
          fwd_pop       = 1'b1;
        end
      end
      default: ;
    endcase
    fwd_entry = head[cur_ch_d];
  end

  // FIFO pointer, occupancy and sticky overflow next-state.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(wr_en[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(pop[c]);
      count_d[c]  = count_q[c] + CNT_W'(wr_en[c]) - CNT_W'(pop[c]);
      ovf_d[c]    = ovf_q[c] | (ch_val_i[c] & ~wr_en[c]);
    end
  end

  // MAC output next-state: strobes for one cycle, data and mod hold when idle.
  always_comb begin
    tx_val_d  = fwd_pop;
    tx_sop_d  = fwd_pop & fwd_entry.sop;
    tx_eop_d  = fwd_pop & fwd_entry.eop;
    tx_mod_d  = fwd_pop ? fwd_entry.mod  : tx_mod_q;
    tx_data_d = fwd_pop ? fwd_entry.data : tx_data_q;
  end

  // Control and output registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_156m25_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        count_q[c]  <= '0;
      end
      ovf_q     <= '0;
      cur_ch_q  <= CH_RST_VAL;
      tx_val_q  <= 1'b0;
      tx_sop_q  <= 1'b0;
      tx_eop_q  <= 1'b0;
      tx_mod_q  <= '0;
      tx_data_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        count_q[c]  <= count_d[c];
      end
      ovf_q     <= ovf_d;
      cur_ch_q  <= cur_ch_d;
      tx_val_q  <= tx_val_d;
      tx_sop_q  <= tx_sop_d;
      tx_eop_q  <= tx_eop_d;
      tx_mod_q  <= tx_mod_d;
      tx_data_q <= tx_data_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk_156m25) begin
    // NOTE: the storage array has no reset; count and pointers alone decide which entries are live.
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en[c]) begin
        fifo_mem[c][wr_ptr_q[c]] <= wr_entry[c];
      end
    end
  end

  assign ch_ovf_o      = ovf_q;
  assign cur_ch_o      = cur_ch_q;
  assign pkt_tx_val_o  = tx_val_q;
  assign pkt_tx_sop_o  = tx_sop_q;
  assign pkt_tx_eop_o  = tx_eop_q;
  assign pkt_tx_mod_o  = tx_mod_q;
  assign pkt_tx_data_o = tx_data_q;

endmodule

// File: tb/tb_xgemac_tx_mux.sv
// Testbench for xgemac_tx_mux: directed scenarios with fixed expectations,
// plus a randomized run checked every cycle against a queue-based model of
// the channel FIFOs and the packet-boundary arbitration rules.

module tb_xgemac_tx_mux;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 16;
  localparam int CH_W   = $clog2(NUM_CH);

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic [63:0] data;
  } ent_t;

  logic                  clk_156m25 = 1'b0;
  logic                  reset_156m25_n = 1'b1;
  logic [NUM_CH*64-1:0]  ch_data_i;
  logic [NUM_CH-1:0]     ch_val_i;
  logic [NUM_CH-1:0]     ch_sop_i;
  logic [NUM_CH-1:0]     ch_eop_i;
  logic [NUM_CH*3-1:0]   ch_mod_i;
  logic [NUM_CH-1:0]     ch_full_o;
  logic [NUM_CH-1:0]     ch_ovf_o;
  logic [63:0]           pkt_tx_data_o;
  logic                  pkt_tx_val_o;
  logic                  pkt_tx_sop_o;
  logic                  pkt_tx_eop_o;
  logic [2:0]            pkt_tx_mod_o;
  logic                  pkt_tx_full_i;
  logic [CH_W-1:0]       cur_ch_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  ent_t        mq [NUM_CH][$];
  logic        m_ovf [NUM_CH];
  logic        m_val, m_sop, m_eop;
  logic [2:0]  m_mod;
  logic [63:0] m_data;
  int          m_cur;
  logic        m_busy;

  xgemac_tx_mux #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(64)) dut (
    .clk_156m25     (clk_156m25),
    .reset_156m25_n (reset_156m25_n),
    .ch_data_i      (ch_data_i),
    .ch_val_i       (ch_val_i),
    .ch_sop_i       (ch_sop_i),
    .ch_eop_i       (ch_eop_i),
    .ch_mod_i       (ch_mod_i),
    .ch_full_o      (ch_full_o),
    .ch_ovf_o       (ch_ovf_o),
    .pkt_tx_data_o  (pkt_tx_data_o),
    .pkt_tx_val_o   (pkt_tx_val_o),
    .pkt_tx_sop_o   (pkt_tx_sop_o),
    .pkt_tx_eop_o   (pkt_tx_eop_o),
    .pkt_tx_mod_o   (pkt_tx_mod_o),
    .pkt_tx_full_i  (pkt_tx_full_i),
    .cur_ch_o       (cur_ch_o)
  );

  always #5 clk_156m25 = ~clk_156m25;

  // ---------------------------------------------------------------- model
  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      mq[c].delete();
      m_ovf[c] = 1'b0;
    end
    m_val = 0; m_sop = 0; m_eop = 0; m_mod = '0; m_data = '0;
    m_cur = NUM_CH - 1;
    m_busy = 1'b0;
  endtask

  // One clock of the block's behaviour, computed from pre-edge model state
  // and the inputs currently driven.
  task automatic model_step();
    int   sel;
    logic fwd;
    ent_t w;
    logic can_wr [NUM_CH];
    sel = -1;
    fwd = 1'b0;
    w   = '0;
    for (int c = 0; c < NUM_CH; c++) can_wr[c] = (mq[c].size() < DEPTH);
    if (!m_busy) begin
      if (!pkt_tx_full_i) begin
        for (int k = 0; k < NUM_CH; k++) begin
          int ci;
`ifdef XGEMAC_TX_MUX_STRICT_PRIO_EN
          ci = k;
`else
          ci = (m_cur + 1 + k) % NUM_CH;
`endif
          if (sel < 0 && mq[ci].size() > 0 && mq[ci][0].sop) sel = ci;
        end
      end
      if (sel >= 0) begin
        fwd   = 1'b1;
        m_cur = sel;
      end else begin
        for (int c = 0; c < NUM_CH; c++)
          if (sel < 0 && mq[c].size() > 0 && !mq[c][0].sop) sel = c;
      end
    end else if (mq[m_cur].size() > 0 && !pkt_tx_full_i) begin
      fwd = 1'b1;
      sel = m_cur;
    end
    if (sel >= 0) w = mq[sel].pop_front();
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_val_i[c]) begin
        if (can_wr[c]) mq[c].push_back('{sop: ch_sop_i[c], eop: ch_eop_i[c],
                                         mod: ch_mod_i[c*3 +: 3], data: ch_data_i[c*64 +: 64]});
        else           m_ovf[c] = 1'b1;
      end
    end
    if (fwd) begin
      m_val = 1'b1; m_sop = w.sop; m_eop = w.eop; m_mod = w.mod; m_data = w.data;
      m_busy = !w.eop;
    end else begin
      m_val = 1'b0; m_sop = 1'b0; m_eop = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic clear_inputs();
    ch_val_i = '0; ch_sop_i = '0; ch_eop_i = '0; ch_mod_i = '0; ch_data_i = '0;
  endtask

  task automatic put_word(input int c, input logic sop, input logic eop,
                          input logic [2:0] mod, input logic [63:0] data);
    ch_val_i[c]          = 1'b1;
    ch_sop_i[c]          = sop;
    ch_eop_i[c]          = eop;
    ch_mod_i[c*3 +: 3]   = mod;
    ch_data_i[c*64 +: 64] = data;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    model_step();
    @(posedge clk_156m25);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    pkt_tx_full_i = 1'b0;
    reset_156m25_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_156m25);
    #1 reset_156m25_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    clear_inputs();
    pkt_tx_full_i = 1'b0;
    #2 reset_156m25_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({pkt_tx_val_o, pkt_tx_sop_o, pkt_tx_eop_o} !== 3'b000) begin
      failures++; $display("FAIL reset_strobes: got %b want 000", {pkt_tx_val_o, pkt_tx_sop_o, pkt_tx_eop_o});
    end
    checks++;
    if ({pkt_tx_data_o, pkt_tx_mod_o} !== 67'd0) begin
      failures++; $display("FAIL reset_data_mod: got %h/%0d want 0/0", pkt_tx_data_o, pkt_tx_mod_o);
    end
    checks++;
    if (cur_ch_o !== CH_W'(NUM_CH - 1)) begin
      failures++; $display("FAIL reset_cur_ch: got %0d want %0d", cur_ch_o, NUM_CH - 1);
    end
    checks++;
    if ({ch_full_o, ch_ovf_o} !== '0) begin
      failures++; $display("FAIL reset_full_ovf: got %b/%b want 0/0", ch_full_o, ch_ovf_o);
    end
    repeat (2) @(posedge clk_156m25);
    #1 reset_156m25_n = 1'b1;
    tick();
    checks++;
    if (pkt_tx_val_o !== 1'b0 || cur_ch_o !== CH_W'(NUM_CH - 1)) begin
      failures++; $display("FAIL reset_idle_after_release: val=%b cur=%0d want 0/%0d", pkt_tx_val_o, cur_ch_o, NUM_CH - 1);
    end
  endtask

  task automatic test_single_packet();
    apply_reset();
    put_word(1, 1'b1, 1'b0, 3'd0, 64'h1111_0000_0000_0000); tick(); clear_inputs();
    checks++;
    if (pkt_tx_val_o !== 1'b0) begin
      failures++; $display("FAIL single_latency_early: val=%b want 0 one cycle after sop write", pkt_tx_val_o);
    end
    put_word(1, 1'b0, 1'b0, 3'd0, 64'h1111_0000_0000_0001); tick(); clear_inputs();
    checks++;
    if ({pkt_tx_val_o, pkt_tx_sop_o, pkt_tx_eop_o, pkt_tx_data_o} !== {3'b110, 64'h1111_0000_0000_0000}) begin
      failures++; $display("FAIL single_word0: got v/s/e=%b data=%h want 110 1111000000000000",
                           {pkt_tx_val_o, pkt_tx_sop_o, pkt_tx_eop_o}, pkt_tx_data_o);
    end
    checks++;
    if (cur_ch_o !== 2'd1) begin
      failures++; $display("FAIL single_cur_ch: got %0d want 1", cur_ch_o);
    end
    put_word(1, 1'b0, 1'b1, 3'd5, 64'h1111_0000_0000_0002); tick(); clear_inputs();
    checks++;
    if ({pkt_tx_val_o, pkt_tx_sop_o, pkt_tx_eop_o, pkt_tx_data_o} !== {3'b100, 64'h1111_0000_0000_0001}) begin
      failures++; $display("FAIL single_word1: got v/s/e=%b data=%h want 100 1111000000000001",
                           {pkt_tx_val_o, pkt_tx_sop_o, pkt_tx_eop_o}, pkt_tx_data_o);
    end
    tick();
    checks++;
    if ({pkt_tx_val_o, pkt_tx_sop_o, pkt_tx_eop_o, pkt_tx_mod_o, pkt_tx_data_o} !==
        {3'b101, 3'd5, 64'h1111_0000_0000_0002}) begin
      failures++; $display("FAIL single_word2: got v/s/e=%b mod=%0d data=%h want 101 5 1111000000000002",
                           {pkt_tx_val_o, pkt_tx_sop_o, pkt_tx_eop_o}, pkt_tx_mod_o, pkt_tx_data_o);
    end
    tick();
    checks++;
    if ({pkt_tx_val_o, pkt_tx_sop_o, pkt_tx_eop_o, pkt_tx_mod_o, pkt_tx_data_o} !==
        {3'b000, 3'd5, 64'h1111_0000_0000_0002}) begin
      failures++; $display("FAIL single_hold: got v/s/e=%b mod=%0d data=%h want 000 5 1111000000000002 (held)",
                           {pkt_tx_val_o, pkt_tx_sop_o, pkt_tx_eop_o}, pkt_tx_mod_o, pkt_tx_data_o);
    end
  endtask

  task automatic test_round_robin();
    ent_t got[$];
    int   got_ch[$];
    apply_reset();
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc < 2)
        for (int c = 0; c < NUM_CH; c++)
          put_word(c, cyc == 0, cyc == 1, 3'd0, 64'hB000 + 64'(c * 16 + cyc));
      tick();
      clear_inputs();
      if (pkt_tx_val_o) begin
        got.push_back('{sop: pkt_tx_sop_o, eop: pkt_tx_eop_o, mod: pkt_tx_mod_o, data: pkt_tx_data_o});
        got_ch.push_back(int'(cur_ch_o));
      end
    end
    checks++;
    if (got.size() != 2 * NUM_CH) begin
      failures++; $display("FAIL rr_word_count: got %0d want %0d", got.size(), 2 * NUM_CH);
    end else begin
      for (int i = 0; i < 2 * NUM_CH; i++) begin
        checks++;
        if (got[i].data !== 64'hB000 + 64'((i / 2) * 16 + (i % 2)) || got_ch[i] != i / 2 ||
            got[i].sop !== (i % 2 == 0) || got[i].eop !== (i % 2 == 1)) begin
          failures++; $display("FAIL rr_order[%0d]: got ch=%0d data=%h s/e=%b%b want ch=%0d data=%h",
                               i, got_ch[i], got[i].data, got[i].sop, got[i].eop,
                               i / 2, 64'hB000 + 64'((i / 2) * 16 + (i % 2)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] got[$];
    int          seen_val;
    apply_reset();
    pkt_tx_full_i = 1'b1;
    seen_val = 0;
    for (int i = 0; i < 6; i++) begin
      put_word(0, i == 0, i == 5, (i == 5) ? 3'd3 : 3'd0, 64'hD000 + 64'(i));
      tick();
      clear_inputs();
      if (pkt_tx_val_o) seen_val++;
    end
    checks++;
    if (seen_val != 0) begin
      failures++; $display("FAIL bp_blocks_grant: got %0d val cycles want 0", seen_val);
    end
    pkt_tx_full_i = 1'b0;
    for (int cyc = 0; cyc < 30 && got.size() < 2; cyc++) begin
      tick();
      if (pkt_tx_val_o) got.push_back(pkt_tx_data_o);
    end
    pkt_tx_full_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (pkt_tx_val_o !== 1'b0) begin
        failures++; $display("FAIL bp_stall[%0d]: got val=%b want 0", i, pkt_tx_val_o);
        got.push_back(pkt_tx_data_o);
      end
    end
    pkt_tx_full_i = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      tick();
      if (pkt_tx_val_o) got.push_back(pkt_tx_data_o);
    end
    checks++;
    if (got.size() != 6) begin
      failures++; $display("FAIL bp_word_count: got %0d want 6", got.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got[i] !== 64'hD000 + 64'(i)) begin
          failures++; $display("FAIL bp_word[%0d]: got %h want %h", i, got[i], 64'hD000 + 64'(i));
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [63:0] got[$];
    apply_reset();
    pkt_tx_full_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      put_word(2, i == 0, i == 15, (i == 15) ? 3'd2 : 3'd0, 64'hC000 + 64'(i));
      tick();
      clear_inputs();
      if (i == 14) begin
        checks++;
        if (ch_full_o !== 4'b0000) begin
          failures++; $display("FAIL ovf_full_early: got %b want 0000 after 15 writes", ch_full_o);
        end
      end
      if (i == 15) begin
        checks++;
        if (ch_full_o !== 4'b0100 || ch_ovf_o !== 4'b0000) begin
          failures++; $display("FAIL ovf_full_at_depth: full=%b ovf=%b want 0100/0000", ch_full_o, ch_ovf_o);
        end
      end
    end
    checks++;
    if (ch_ovf_o !== 4'b0100 || ch_full_o !== 4'b0100) begin
      failures++; $display("FAIL ovf_set: full=%b ovf=%b want 0100/0100", ch_full_o, ch_ovf_o);
    end
    pkt_tx_full_i = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (pkt_tx_val_o) got.push_back(pkt_tx_data_o);
    end
    checks++;
    if (got.size() != 16) begin
      failures++; $display("FAIL ovf_drain_count: got %0d want 16", got.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got[i] !== 64'hC000 + 64'(i)) begin
          failures++; $display("FAIL ovf_drain_word[%0d]: got %h want %h", i, got[i], 64'hC000 + 64'(i));
        end
      end
    end
    checks++;
    if (ch_ovf_o !== 4'b0100 || ch_full_o !== 4'b0000) begin
      failures++; $display("FAIL ovf_sticky: full=%b ovf=%b want 0000/0100", ch_full_o, ch_ovf_o);
    end
  endtask

  task automatic test_orphan();
    ent_t got[$];
    apply_reset();
    put_word(3, 1'b0, 1'b0, 3'd0, 64'hEEEE_0000_0000_0BAD); tick(); clear_inputs();
    put_word(3, 1'b1, 1'b0, 3'd0, 64'hE000);                tick(); clear_inputs();
    put_word(3, 1'b0, 1'b1, 3'd7, 64'hE001);                tick(); clear_inputs();
    if (pkt_tx_val_o) got.push_back('{sop: pkt_tx_sop_o, eop: pkt_tx_eop_o, mod: pkt_tx_mod_o, data: pkt_tx_data_o});
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      if (pkt_tx_val_o) got.push_back('{sop: pkt_tx_sop_o, eop: pkt_tx_eop_o, mod: pkt_tx_mod_o, data: pkt_tx_data_o});
    end
    checks++;
    if (got.size() != 2) begin
      failures++; $display("FAIL orphan_word_count: got %0d want 2", got.size());
    end else begin
      checks++;
      if (got[0] !== ent_t'({1'b1, 1'b0, 3'd0, 64'hE000}) || got[1] !== ent_t'({1'b0, 1'b1, 3'd7, 64'hE001})) begin
        failures++; $display("FAIL orphan_packet: got %h,%h want packet E000/E001 only", got[0], got[1]);
      end
    end
    checks++;
    if (cur_ch_o !== 2'd3) begin
      failures++; $display("FAIL orphan_cur_ch: got %0d want 3", cur_ch_o);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [63:0] got[$];
    int          stray;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      put_word(1, i == 0, 1'b0, 3'd0, 64'hF100 + 64'(i));
      tick();
      clear_inputs();
    end
    checks++;
    if (pkt_tx_val_o !== 1'b1 || cur_ch_o !== 2'd1) begin
      failures++; $display("FAIL rstmid_in_xfer: val=%b cur=%0d want 1/1", pkt_tx_val_o, cur_ch_o);
    end
    #2 reset_156m25_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({pkt_tx_val_o, pkt_tx_sop_o, pkt_tx_eop_o, pkt_tx_mod_o, pkt_tx_data_o} !== '0 ||
        cur_ch_o !== CH_W'(NUM_CH - 1) || ch_full_o !== '0 || ch_ovf_o !== '0) begin
      failures++; $display("FAIL rstmid_immediate: val=%b data=%h cur=%0d full=%b ovf=%b want all 0, cur=%0d",
                           pkt_tx_val_o, pkt_tx_data_o, cur_ch_o, ch_full_o, ch_ovf_o, NUM_CH - 1);
    end
    @(posedge clk_156m25);
    #1 reset_156m25_n = 1'b1;
    stray = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      if (pkt_tx_val_o) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++; $display("FAIL rstmid_partial_lost: got %0d val cycles want 0", stray);
    end
    put_word(0, 1'b1, 1'b0, 3'd0, 64'hF200); tick(); clear_inputs();
    put_word(0, 1'b0, 1'b1, 3'd1, 64'hF201); tick(); clear_inputs();
    if (pkt_tx_val_o) got.push_back(pkt_tx_data_o);
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick();
      if (pkt_tx_val_o) got.push_back(pkt_tx_data_o);
    end
    checks++;
    if (got.size() != 2 || got[0] !== 64'hF200 || got[1] !== 64'hF201 || cur_ch_o !== 2'd0) begin
      failures++; $display("FAIL rstmid_new_packet: count=%0d cur=%0d want 2 words F200,F201 on ch 0",
                           got.size(), cur_ch_o);
    end
  endtask

  task automatic test_random();
    int          gen_left [NUM_CH];
    int          seq;
    int          n_val;
    logic [NUM_CH-1:0] exp_full, exp_ovf;
    apply_reset();
    seq = 0;
    n_val = 0;
    for (int c = 0; c < NUM_CH; c++) gen_left[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      clear_inputs();
      pkt_tx_full_i = ($urandom_range(0, 99) < 25);
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 99) < 22) begin
          logic [63:0] d;
          seq++;
          d = {8'(c), 24'(seq), 32'($urandom)};
          if (gen_left[c] == 0) begin
            if ($urandom_range(0, 9) == 0) begin
              put_word(c, 1'b0, 1'b0, 3'($urandom), d);
            end else begin
              gen_left[c] = $urandom_range(2, 6) - 1;
              put_word(c, 1'b1, 1'b0, 3'($urandom), d);
            end
          end else begin
            gen_left[c]--;
            put_word(c, 1'b0, gen_left[c] == 0, 3'($urandom), d);
          end
        end
      end
      tick();
      for (int c = 0; c < NUM_CH; c++) begin
        exp_full[c] = (mq[c].size() == DEPTH);
        exp_ovf[c]  = m_ovf[c];
      end
      if (pkt_tx_val_o) n_val++;
      checks++;
      if ({pkt_tx_val_o, pkt_tx_sop_o, pkt_tx_eop_o} !== {m_val, m_sop, m_eop}) begin
        failures++; $display("FAIL rand_strobes cyc=%0d: got %b want %b", cyc,
                             {pkt_tx_val_o, pkt_tx_sop_o, pkt_tx_eop_o}, {m_val, m_sop, m_eop});
      end
      checks++;
      if (pkt_tx_data_o !== m_data || pkt_tx_mod_o !== m_mod) begin
        failures++; $display("FAIL rand_data cyc=%0d: got %h/%0d want %h/%0d", cyc,
                             pkt_tx_data_o, pkt_tx_mod_o, m_data, m_mod);
      end
      checks++;
      if (cur_ch_o !== CH_W'(m_cur)) begin
        failures++; $display("FAIL rand_cur_ch cyc=%0d: got %0d want %0d", cyc, cur_ch_o, m_cur);
      end
      checks++;
      if (ch_full_o !== exp_full || ch_ovf_o !== exp_ovf) begin
        failures++; $display("FAIL rand_flags cyc=%0d: full=%b ovf=%b want %b/%b", cyc,
                             ch_full_o, ch_ovf_o, exp_full, exp_ovf);
      end
    end
    clear_inputs();
    pkt_tx_full_i = 1'b0;
    checks++;
    if (n_val < 500) begin
      failures++; $display("FAIL rand_activity: got %0d forwarded words want at least 500", n_val);
    end
  endtask

  initial begin
    clear_inputs();
    pkt_tx_full_i = 1'b0;
    model_reset();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_orphan();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
